// File: rtl/edac_scrubber.sv
// Background EDAC memory scrubber.
// Walks every RAM address, reads it through the Hamming decoder, writes corrected
// codewords back on single-bit errors and counts corrected/uncorrectable events.
// User traffic always wins: scrub strobes are withheld whenever the user port is active.
module edac_scrubber #(
    parameter int unsigned DAT_WIDTH    = 16,
    parameter int unsigned PAR_WIDTH    = 5,
    parameter int unsigned RAM_LOGDEPTH = 8,
    parameter int unsigned RD_LAT       = 2,
    parameter int unsigned PERIOD       = 1024,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                           clk,
    input  logic                           nGrst,
    input  logic                           scrub_en,
    input  logic                           user_rEn,
    input  logic                           user_wEn,
    input  logic [RAM_LOGDEPTH-1:0]        user_wA,
    input  logic                           errFlag,
    input  logic                           correctable,
    input  logic [PAR_WIDTH+DAT_WIDTH-1:0] re_code,
    output logic                           scrub_rEn,
    output logic [RAM_LOGDEPTH-1:0]        scrub_rA,
    output logic                           scrub_wEn,
    output logic [RAM_LOGDEPTH-1:0]        scrub_wA,
    output logic [PAR_WIDTH+DAT_WIDTH-1:0] scrub_wD,
    output logic                           scrub_busy,
    output logic [CNT_WIDTH-1:0]           corr_cnt,
    output logic [CNT_WIDTH-1:0]           uncorr_cnt,
    output logic                           uncorr_flag,
    output logic [RAM_LOGDEPTH-1:0]        uncorr_addr,
    output logic                           sweep_done
);

    localparam int unsigned CW    = PAR_WIDTH + DAT_WIDTH;
    localparam int unsigned TMR_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [TMR_W-1:0]        TMR_RELOAD = TMR_W'(PERIOD - 1);
    localparam logic [LAT_W-1:0]        LAT_RELOAD = LAT_W'(RD_LAT - 1);
    localparam logic [RAM_LOGDEPTH-1:0] ADDR_MAX   = '1;

    typedef enum logic [2:0] {
        StIdle,
        StWaitTmr,
        StRead,
        StWaitDec,
        StWrite
    } state_e;

    state_e                  state_q, state_d;
    logic [RAM_LOGDEPTH-1:0] addr_q, addr_d;
    logic [TMR_W-1:0]        tmr_q, tmr_d;
    logic [LAT_W-1:0]        lat_q, lat_d;
    logic                    stale_q, stale_d;
    logic [CNT_WIDTH-1:0]    corr_q, corr_d;
    logic [CNT_WIDTH-1:0]    uncorr_q, uncorr_d;
    logic                    flag_q, flag_d;
    logic [RAM_LOGDEPTH-1:0] uaddr_q, uaddr_d;
    logic [CW-1:0]           wd_q, wd_d;

    logic user_busy;
    logic wa_hit;
    logic stale_now;
    logic advance;

    assign user_busy = user_rEn | user_wEn;
    // A user write to the address being scrubbed makes any decoded copy obsolete.
    assign wa_hit    = user_wEn & (user_wA == addr_q);

    // State register.
    always_ff @(posedge clk or negedge nGrst) begin
        if (!nGrst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: address, timers, stale bit, counters and captures.
    always_ff @(posedge clk or negedge nGrst) begin
        if (!nGrst) begin
            addr_q   <= '0;
            tmr_q    <= '0;
            lat_q    <= '0;
            stale_q  <= 1'b0;
            corr_q   <= '0;
            uncorr_q <= '0;
            flag_q   <= 1'b0;
            uaddr_q  <= '0;
            wd_q     <= '0;
        end else begin
            addr_q   <= addr_d;
            tmr_q    <= tmr_d;
            lat_q    <= lat_d;
            stale_q  <= stale_d;
            corr_q   <= corr_d;
            uncorr_q <= uncorr_d;
            flag_q   <= flag_d;
            uaddr_q  <= uaddr_d;
            wd_q     <= wd_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        tmr_d     = tmr_q;
        lat_d     = lat_q;
        stale_d   = stale_q;
        corr_d    = corr_q;
        uncorr_d  = uncorr_q;
        flag_d    = flag_q;
        uaddr_d   = uaddr_q;
        wd_d      = wd_q;
        stale_now = stale_q;
        advance   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (scrub_en) begin
                    tmr_d   = TMR_RELOAD;
                    state_d = StWaitTmr;
                end
            end
            StWaitTmr: begin
                if (!scrub_en) begin
                    state_d = StIdle;
                end else if (tmr_q == '0) begin
                    state_d = StRead;
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
            end
            StRead: begin
                if (!scrub_en) begin
                    state_d = StIdle;
                end else if (!user_busy) begin
                    lat_d   = LAT_RELOAD;
                    stale_d = 1'b0;
                    state_d = StWaitDec;
                end
            end
            StWaitDec: begin
                // scrub_en is deliberately ignored until the read has been evaluated.
                stale_now = stale_q | wa_hit;
                stale_d   = stale_now;
                if (lat_q != '0) begin
                    lat_d = lat_q - 1'b1;
                end else if (errFlag && correctable) begin
                    if (corr_q != '1) begin
                        corr_d = corr_q + 1'b1;
                    end
                    wd_d = re_code;
                    if (stale_now) begin
                        advance = 1'b1;
                    end else begin
                        state_d = StWrite;
                    end
                end else begin
                    if (errFlag) begin
                        if (uncorr_q != '1) begin
                            uncorr_d = uncorr_q + 1'b1;
                        end
                        if (!flag_q) begin
                            flag_d  = 1'b1;
                            uaddr_d = addr_q;
                        end
                    end
                    advance = 1'b1;
                end
            end
            StWrite: begin
                // Abandon on a colliding user write, otherwise wait for a free port.
                if (wa_hit || !user_busy) begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (advance) begin
            addr_d  = addr_q + 1'b1;
            tmr_d   = TMR_RELOAD;
            state_d = scrub_en ? StWaitTmr : StIdle;
        end
    end

    // Strobes, busy and sweep pulse.
    always_comb begin
        scrub_rEn  = 1'b0;
        scrub_wEn  = 1'b0;
        scrub_busy = 1'b0;
        unique case (state_q)
            StRead: begin
                scrub_rEn = scrub_en & ~user_busy;
            end
            StWaitDec: begin
                scrub_busy = 1'b1;
            end
            StWrite: begin
                scrub_busy = 1'b1;
                scrub_wEn  = ~user_busy;
            end
            default: begin
                scrub_rEn = 1'b0;
            end
        endcase
        sweep_done = advance & (addr_q == ADDR_MAX);
    end

    assign scrub_rA    = addr_q;
    assign scrub_wA    = addr_q;
    assign scrub_wD    = wd_q;
    assign corr_cnt    = corr_q;
    assign uncorr_cnt  = uncorr_q;
    assign uncorr_flag = flag_q;
    assign uncorr_addr = uaddr_q;

endmodule

// File: doc/edac_scrubber.md
Name: edac_scrubber

Overview:
- Background memory scrubber downstream of the EDAC Hamming decoder.
- Sweeps every RAM address and issues reads whose codewords pass through the decoder.
- Consumes errFlag, correctable and re_code; writes corrected codewords back to the RAM write port on single-bit errors.
- Counts corrected and uncorrectable events; yields to user traffic at all times.

Parameters:
- DAT_WIDTH, 16, data bits per codeword
- PAR_WIDTH, 5, parity bits per codeword
- RAM_LOGDEPTH, 8, address width; sweep covers 0..2^RAM_LOGDEPTH-1
- RD_LAT, 2, cycles from scrub_rEn to valid decoder outputs (RAM_PIPE+DEC_PIPE+1); must be >=1
- PERIOD, 1024, idle cycles between successive scrub reads; must be >=1
- CNT_WIDTH, 16, width of the event counters

Ports:
- clk  in  1  single clock for RAM read/write side and decoder
- nGrst  in  1  asynchronous active-low reset
- scrub_en  in  1  level enable; low parks the FSM in IDLE
- user_rEn  in  1  user read request this cycle (priority over scrub)
- user_wEn  in  1  user write request this cycle (priority over scrub)
- user_wA  in  RAM_LOGDEPTH  user write address, used for collision check
- errFlag  in  1  decoder error flag
- correctable  in  1  decoder single-bit-correctable flag
- re_code  in  PAR_WIDTH+DAT_WIDTH  decoder corrected codeword
- scrub_rEn  out  1  RAM read strobe from scrubber
- scrub_rA  out  RAM_LOGDEPTH  scrub read address
- scrub_wEn  out  1  RAM write strobe for correction write-back
- scrub_wA  out  RAM_LOGDEPTH  write-back address
- scrub_wD  out  PAR_WIDTH+DAT_WIDTH  write-back codeword
- scrub_busy  out  1  high while a scrub read or write-back is in flight
- corr_cnt  out  CNT_WIDTH  saturating count of corrected words
- uncorr_cnt  out  CNT_WIDTH  saturating count of uncorrectable words
- uncorr_flag  out  1  sticky; set on first uncorrectable word
- uncorr_addr  out  RAM_LOGDEPTH  address of first uncorrectable word
- sweep_done  out  1  one-cycle pulse when address wraps from max back to 0

Behaviour:
- Reset (nGrst low, async): state IDLE, address 0, timer 0. All outputs are 0, including counters, flag, uncorr_addr, scrub_wD and sweep_done.
- States: IDLE, WAIT_TMR, READ, WAIT_DEC, WRITE.
- IDLE: if scrub_en is high, load timer = PERIOD-1 and go to WAIT_TMR.
- WAIT_TMR: decrement the timer each cycle. At 0, go to READ. If scrub_en goes low, go to IDLE.
- READ:
  - If user_rEn or user_wEn is high, hold and drive no strobe.
  - Otherwise drive scrub_rEn=1 with scrub_rA=addr for exactly one cycle, load latency counter = RD_LAT-1, and go to WAIT_DEC.
  - scrub_en low in READ: go to IDLE.
- WAIT_DEC:
  - Count down. scrub_en is ignored until the read completes.
  - If user_wEn=1 with user_wA==addr in any cycle of WAIT_DEC, set the internal stale bit.
  - On the evaluate cycle (counter 0, i.e. RD_LAT cycles after scrub_rEn), sample the decoder:
    - errFlag=0: no action.
    - errFlag=1, correctable=1: increment corr_cnt (saturating at all-ones). Capture scrub_wD=re_code. If not stale, go to WRITE; if stale, skip the write-back.
    - errFlag=1, correctable=0: increment uncorr_cnt (saturating). If uncorr_flag=0, set it and capture uncorr_addr=addr. No write-back.
  - Unless entering WRITE, advance the address and go to WAIT_TMR (timer reload) or IDLE if scrub_en=0.
- WRITE:
  - If user_wEn=1 with user_wA==addr: abandon the write-back.
  - Else if user_wEn or user_rEn is high: hold.
  - Else drive scrub_wEn=1 with scrub_wA=addr for one cycle.
  - Then advance the address and go to WAIT_TMR, or IDLE if scrub_en=0.
- Address advance: addr+1 modulo 2^RAM_LOGDEPTH. When addr was all-ones, pulse sweep_done in the advance cycle.
- scrub_busy = 1 in READ (after the strobe), WAIT_DEC and WRITE; otherwise 0.
- scrub_rEn and scrub_wEn are never high together, and never high in a cycle where user_rEn or user_wEn is high.
- Counters and flag clear only on reset.
- The stale bit clears on every read issue.

Test Plan:
- RAM_LOGDEPTH=3, PERIOD=4, RD_LAT=2, clean memory, scrub_en=1 -> scrub_rEn pulses at addresses 0..7, one every 7 cycles. sweep_done pulses once after addr 7. Counters stay 0.
- Single-bit error injected at addr 5 (errFlag=1, correctable=1, re_code=0x1ABCD) -> corr_cnt=1, scrub_wEn one cycle with scrub_wA=5, scrub_wD=0x1ABCD. Next read occurs at addr 6.
- Double-bit error at addr 2, then at addr 6 -> uncorr_cnt=2, uncorr_flag=1, uncorr_addr=2. No scrub_wEn is issued.
- user_rEn held high for 10 cycles while in READ -> no scrub_rEn during those cycles. The read issues the cycle after user_rEn falls.
- user_wEn with user_wA=5 during WAIT_DEC for a correctable error at addr 5 -> corr_cnt increments, no write-back is issued, and addr advances to 6.
- nGrst asserted mid-WAIT_DEC with corr_cnt=3 -> all outputs 0 immediately. After release, scrubbing restarts at addr 0.
- CNT_WIDTH=2 with 5 correctable errors -> corr_cnt saturates at 3.
